// File: rtl/tpiu_frame_decode_if.sv
// ---------------------------------------------------------------------------
// tpiu_frame_decode_if
//    Bundles the frame-input strobes and the decoded byte-stream handshake
//    of tpiu_frame_decode.
//
//    master : the environment (trace-pin stage upstream + byte consumer)
//    slave  : the decoder
//
//    WdAvail/PacketWd      one 16-bit frame word per strobe
//    PacketReset           discard the partially filled frame
//    PacketCommit          frame complete
//    ByteValid/ByteReady   decoded byte handshake
//    ByteOut/StreamId      decoded byte and the stream ID in force for it
//    FrameDrop/DropCount   dropped-frame pulse and saturating count
// ---------------------------------------------------------------------------
interface tpiu_frame_decode_if;
   logic        WdAvail;
   logic [15:0] PacketWd;
   logic        PacketReset;
   logic        PacketCommit;
   logic        ByteValid;
   logic [7:0]  ByteOut;
   logic [6:0]  StreamId;
   logic        ByteReady;
   logic        FrameDrop;
   logic [7:0]  DropCount;

   modport master (
      output WdAvail, PacketWd, PacketReset, PacketCommit, ByteReady,
      input  ByteValid, ByteOut, StreamId, FrameDrop, DropCount
   );

   modport slave (
      input  WdAvail, PacketWd, PacketReset, PacketCommit, ByteReady,
      output ByteValid, ByteOut, StreamId, FrameDrop, DropCount
   );
endinterface

// File: rtl/tpiu_frame_decode.sv
// ---------------------------------------------------------------------------
// tpiu_frame_decode
//    Unpacks 16-byte TPIU formatter frames into (stream ID, data byte) pairs,
//    one byte per cycle over a valid/ready handshake. Incoming words are
//    collected in a staging register and copied into one of two ping-pong
//    frame buffers on a good commit; a commit with the wrong word count or
//    with no free buffer is dropped and counted.
//
//    Parameter DROP_NULL : 1 = bytes of stream 0x00 are consumed silently.
//    clk   : system clock, rising edge
//    rst   : asynchronous reset, active low
//    bus   : tpiu_frame_decode_if.slave (word input, byte output, drop stats)
// ---------------------------------------------------------------------------
module tpiu_frame_decode #(
   parameter bit DROP_NULL = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   tpiu_frame_decode_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, SLOT, DONE} state_t;

   state_t       state_q;
   logic [15:0]  stage_q [8];
   logic [127:0] frame_q [2];
   logic [1:0]   full_q, full_d;
   logic         fillSel_q, drainSel_q;
   logic [3:0]   wrCnt_q;
   logic         frameDrop_q;
   logic [7:0]   dropCount_q;
   logic [3:0]   slot_q;
   logic [6:0]   curId_q, pendId_q;
   logic         pendValid_q;
   logic         byteValid_q;
   logic [7:0]   byteOut_q;
   logic [6:0]   streamId_q;

   logic         wordWr, bufRelease, fillFree, commitOk, commitBad;
   logic [127:0] drainFrame;
   logic [7:0]   auxByte, curByte, nxtByte, nxtData;
   logic         curAux, curIsId, nxtAux, nxtIsId, nxtShow, advance;
   logic [3:0]   nxtIdx;
   logic [6:0]   idAfter;
   logic         pendSet, pendClr;

   // Fill-side decisions. PacketReset outranks everything; a commit swallows
   // a coincident word strobe. The buffer being released in DONE this cycle
   // counts as free so a back-to-back commit can take it.
   assign wordWr     = bus.WdAvail && !bus.PacketReset && !bus.PacketCommit &&
                       (wrCnt_q < 4'd8);
   assign bufRelease = (state_q == DONE);
   assign fillFree   = !full_q[fillSel_q] || (bufRelease && (drainSel_q == fillSel_q));
   assign commitOk   = bus.PacketCommit && !bus.PacketReset && (wrCnt_q == 4'd8) && fillFree;
   assign commitBad  = bus.PacketCommit && !bus.PacketReset && !commitOk;

   // Buffer occupancy: release from DONE, set on an accepted commit.
   always_comb begin
      full_d = full_q;
      if (bufRelease) full_d[drainSel_q] = 1'b0;
      if (commitOk)   full_d[fillSel_q]  = 1'b1;
   end

   // Data storage needs no reset; occupancy flags decide what is meaningful.
   always_ff @(posedge clk) begin
      if (wordWr)   stage_q[wrCnt_q[2:0]] <= bus.PacketWd;
      if (commitOk) frame_q[fillSel_q] <= {stage_q[7], stage_q[6], stage_q[5], stage_q[4],
                                           stage_q[3], stage_q[2], stage_q[1], stage_q[0]};
   end

   // Fill-side control: word counter, ping-pong fill pointer, drop statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrCnt_q     <= 4'd0;
         full_q      <= 2'b00;
         fillSel_q   <= 1'b0;
         frameDrop_q <= 1'b0;
         dropCount_q <= 8'd0;
      end else begin
         full_q      <= full_d;
         frameDrop_q <= commitBad;
         if (bus.PacketReset || bus.PacketCommit) wrCnt_q <= 4'd0;
         else if (wordWr)                          wrCnt_q <= wrCnt_q + 4'd1;
         if (commitOk) fillSel_q <= ~fillSel_q;
         if (commitBad && (dropCount_q != 8'hFF)) dropCount_q <= dropCount_q + 8'd1;
      end
   end

   // Decode of the slot currently held (slot_q). Aux bit for byte s lives in
   // byte15[s>>1], which also gives byte15[7] for byte 14. idAfter is the ID
   // in force once the current slot completes: an immediate ID change takes
   // effect now, a delayed one (aux=1, or any change in slot 14) is parked in
   // the pending register, and a pending ID lands once the following data
   // slot has been handshaken.
   always_comb begin
      drainFrame = frame_q[drainSel_q];
      auxByte    = drainFrame[127:120];
      curByte    = drainFrame[{slot_q, 3'b000} +: 8];
      curAux     = auxByte[slot_q[3:1]];
      curIsId    = !slot_q[0] && curByte[0];
      idAfter    = curId_q;
      pendSet    = 1'b0;
      pendClr    = 1'b0;
      if (state_q == SLOT) begin
         if (curIsId) begin
            if (!curAux && (slot_q != 4'd14)) idAfter = curByte[7:1];
            else                              pendSet = 1'b1;
         end else if (pendValid_q) begin
            idAfter = pendId_q;
            pendClr = 1'b1;
         end
      end
   end

   // Look-ahead decode of the slot about to be entered, so the registered
   // outputs present it on the very edge the FSM moves into it. Even bytes
   // with bit0 clear carry their true LSB in the aux bit.
   always_comb begin
      nxtIdx  = (state_q == IDLE) ? 4'd0 : slot_q + 4'd1;
      nxtByte = drainFrame[{nxtIdx, 3'b000} +: 8];
      nxtAux  = auxByte[nxtIdx[3:1]];
      nxtIsId = !nxtIdx[0] && nxtByte[0];
      nxtData = nxtIdx[0] ? nxtByte : {nxtByte[7:1], nxtAux};
      nxtShow = !nxtIsId && !(DROP_NULL && (idAfter == 7'd0));
      advance = !(byteValid_q && !bus.ByteReady);
   end

   // Decoder FSM. Every slot, shown or not, occupies one cycle; a shown byte
   // holds its slot until accepted. DONE hands the buffer back, flips the
   // drain pointer and applies an ID change parked by slot 14.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         slot_q      <= 4'd0;
         drainSel_q  <= 1'b0;
         curId_q     <= 7'd0;
         pendId_q    <= 7'd0;
         pendValid_q <= 1'b0;
         byteValid_q <= 1'b0;
         byteOut_q   <= 8'd0;
         streamId_q  <= 7'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (full_q[drainSel_q]) begin
                  state_q     <= SLOT;
                  slot_q      <= 4'd0;
                  byteValid_q <= nxtShow;
                  byteOut_q   <= nxtData;
                  streamId_q  <= idAfter;
               end
            end
            SLOT: begin
               if (advance) begin
                  curId_q    <= idAfter;
                  streamId_q <= idAfter;
                  if (pendSet) begin
                     pendId_q    <= curByte[7:1];
                     pendValid_q <= 1'b1;
                  end else if (pendClr) begin
                     pendValid_q <= 1'b0;
                  end
                  if (slot_q == 4'd14) begin
                     state_q     <= DONE;
                     byteValid_q <= 1'b0;
                  end else begin
                     slot_q      <= nxtIdx;
                     byteValid_q <= nxtShow;
                     byteOut_q   <= nxtData;
                  end
               end
            end
            DONE: begin
               drainSel_q <= ~drainSel_q;
               if (pendValid_q) begin
                  curId_q     <= pendId_q;
                  streamId_q  <= pendId_q;
                  pendValid_q <= 1'b0;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ByteValid = byteValid_q;
   assign bus.ByteOut   = byteOut_q;
   assign bus.StreamId  = streamId_q;
   assign bus.FrameDrop = frameDrop_q;
   assign bus.DropCount = dropCount_q;

endmodule
